// File: rtl/mac_sequencer.sv
// Sequencer for the shared 8x8 multiply / 16-bit accumulate datapath: fetch, multiply, accumulate, report.
// Optional build macro SATURATE_EN: the result clamps to all-ones on carry-out instead of wrapping.
module mac_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 4,
  parameter int ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W+1)'(MAX_LEN);

  state_t                state_q, state_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  drain_q, drain_d;
  logic                  vld1_q, vld1_d;   // operands on rd_a/rd_b this cycle
  logic                  vld2_q, vld2_d;   // prod_q holds an element this cycle
  logic [2*DATA_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]      result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  err_q, err_d;
  logic [ACC_W:0]        sum;

  // NOTE: every variable gets its default before any branch so the block never infers a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    vld1_d     = 1'b0;
    vld2_d     = vld1_q;
    prod_d     = prod_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    err_d      = 1'b0;

    sum = {1'b0, result_q} + (ACC_W+1)'(prod_q);
    if (vld2_q) begin
      result_d   = sum[ACC_W-1:0];
      overflow_d = overflow_q | sum[ACC_W];
`ifdef SATURATE_EN
      if (overflow_d) result_d = '1;
`endif
    end
    if (vld1_q) prod_d = (2*DATA_W)'(rd_a) * (2*DATA_W)'(rd_b);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0 && len <= MAX_LEN_L) begin
            state_d    = S_FETCH;
            len_d      = len;
            addr_d     = '0;
            result_d   = '0;
            overflow_d = 1'b0;
            prod_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        vld1_d = 1'b1;
        if (addr_q == ADDR_W'(len_q - 1'b1)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything in flight, but leaves an idle block untouched.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      vld1_d     = 1'b0;
      vld2_d     = 1'b0;
      result_d   = '0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      prod_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      prod_q     <= prod_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign rd_en    = (state_q == S_FETCH) && !abort;
  assign rd_addr  = addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) && !abort;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed vector table, multi-cycle corner cases, random ops vs a model.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  len = '0;
  logic        abort = 1'b0;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_a, rd_b;
  logic        busy, done, overflow, err;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];

  mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  // Registered vector storage; junk appears when no read was issued.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
    end else begin
      rd_a <= 8'($urandom);
      rd_b <= 8'($urandom);
    end
  end

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = a[8*i +: 8];
      mem_b[i] = b[8*i +: 8];
    end
  endtask

  // Dot product from the arithmetic rules: 17-bit add, sticky carry, wrap or clamp.
  task automatic model(input int n, output logic [15:0] res, output logic ovf);
    int acc;
    int s;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = acc + int'(mem_a[i]) * int'(mem_b[i]);
      if (s > 65535) ovf = 1'b1;
      acc = s % 65536;
`ifdef SATURATE_EN
      if (ovf) acc = 65535;
`endif
    end
    res = 16'(acc);
  endtask

  // Start an operation and follow it cycle by cycle to the done pulse.
  task automatic run_op(input int n, input logic [15:0] er, input logic eo, input string tag);
    start = 1'b1;
    len   = 3'(n);
    tick();
    start = 1'b0;
    len   = 3'($urandom_range(0, 7));
    for (int c = 1; c <= n + 3; c++) begin
      if (c <= n) begin
        check({tag, "_rd_en"}, 32'(rd_en), 32'(1));
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'(c - 1));
      end else begin
        check({tag, "_rd_en_off"}, 32'(rd_en), 32'(0));
      end
      check({tag, "_busy"}, 32'(busy), 32'(1));
      check({tag, "_done"}, 32'(done), 32'(c == n + 3));
      if (c == n + 3) begin
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
      end
      tick();
    end
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_held_result"}, 32'(result), 32'(er));
    check({tag, "_addr_hold"}, 32'(rd_addr), 32'(n - 1));
  endtask

  vec_t vecs [5];

  initial begin
    logic [15:0] er;
    logic        eo;

    vecs[0] = '{4, 32'h04030201, 32'h08070605, 16'h0046, 1'b0};
`ifdef SATURATE_EN
    vecs[1] = '{2, 32'h0000FFFF, 32'h0000FFFF, 16'hFFFF, 1'b1};
`else
    vecs[1] = '{2, 32'h0000FFFF, 32'h0000FFFF, 16'hFC02, 1'b1};
`endif
    vecs[2] = '{1, 32'h00000003, 32'h00000009, 16'h001B, 1'b0};
    vecs[3] = '{3, 32'h00808080, 32'h00808080, 16'hC000, 1'b0};
`ifdef SATURATE_EN
    vecs[4] = '{4, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 1'b1};
`else
    vecs[4] = '{4, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hF804, 1'b1};
`endif

    // Reset state
    load(32'h0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    check("rst_rd_en", 32'(rd_en), 32'(0));
    check("rst_rd_addr", 32'(rd_addr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    rst = 1'b0;
    tick();

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].a, vecs[i].b);
      run_op(vecs[i].n, vecs[i].res, vecs[i].ovf, $sformatf("vec%0d", i));
      tick();
    end

    // Illegal lengths: error pulse, no state change, result untouched
    load(32'h00000003, 32'h00000009);
    run_op(1, 16'h001B, 1'b0, "len1");
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      len   = (k == 0) ? 3'd0 : ((k == 1) ? 3'd5 : 3'd7);
      tick();
      start = 1'b0;
      check("err_pulse", 32'(err), 32'(1));
      check("err_busy", 32'(busy), 32'(0));
      tick();
      check("err_clear", 32'(err), 32'(0));
      check("err_result", 32'(result), 32'(16'h001B));
    end

    // Abort in cycle 2 after an overflowing op
    load(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(4, vecs[4].res, 1'b1, "pre_abort");
    start = 1'b1;
    len   = 3'd4;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_overflow", 32'(overflow), 32'(0));
    for (int c = 0; c < 10; c++) begin
      check("abort_no_done", 32'(done), 32'(0));
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_noeffect", 32'(busy), 32'(0));

    // Start re-pulsed during FETCH and during DONE is ignored
    load(32'h04030201, 32'h08070605);
    start = 1'b1;
    len   = 3'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check("ign_done", 32'(done), 32'(c == 7));
      if (c == 7) check("ign_result", 32'(result), 32'(16'h0046));
      start = (c == 2 || c == 7);
      len   = 3'd1;
      tick();
      start = 1'b0;
    end
    check("ign_done_start_idle", 32'(busy), 32'(0));
    load(32'h00000003, 32'h00000009);
    run_op(1, 16'h001B, 1'b0, "after_ign");

    // Synchronous reset during DRAIN, then a normal run
    load(32'h04030201, 32'h08070605);
    start = 1'b1;
    len   = 3'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("drain_rst_busy", 32'(busy), 32'(0));
    check("drain_rst_done", 32'(done), 32'(0));
    check("drain_rst_result", 32'(result), 32'(0));
    check("drain_rst_rd_addr", 32'(rd_addr), 32'(0));
    check("drain_rst_rd_en", 32'(rd_en), 32'(0));
    run_op(4, 16'h0046, 1'b0, "post_rst");

    // Random operations against the arithmetic model
    for (int t = 0; t < 24; t++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        mem_a[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        mem_b[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      end
      model(n, er, eo);
      run_op(n, er, eo, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
